regfile_read_port: RTL and testbench
====================================

Name: regfile_read_port

Overview:
- Read-side companion to the 32x32 register storage block. It consumes the parallel register outputs and the per-register write-control vector.
- It serves two independent read channels (A, B) through valid/ready handshakes with a registered 1-cycle response.
- Reads forward the write-back value when the addressed register is being written in the same cycle.
- A debug dump FSM streams all 32 registers, in order, out of channel A.

Parameters:
- NREG, 32, number of registers; address width is clog2(NREG) = 5.
- W, 32, data width.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- reg_q  input  [W-1:0] x NREG (unpacked)  current register contents from storage.
- rw_ctrl  input  NREG  per-register control as driven to storage; 0 = write this cycle, 1 = hold/read.
- wr_data  input  W  write-back value presented to storage this cycle.
- a_req_valid  input  1  channel A request valid.
- a_req_ready  output  1  channel A can accept a request.
- a_addr  input  5  channel A register index.
- a_rsp_valid  output  1  channel A response valid.
- a_rsp_ready  input  1  channel A consumer accepts the response.
- a_rsp_data  output  W  channel A read data.
- a_rsp_idx  output  5  register index of the channel A response.
- b_req_valid, b_req_ready, b_addr, b_rsp_valid, b_rsp_ready, b_rsp_data, b_rsp_idx: same as channel A, for channel B.
- dump_start  input  1  single-cycle pulse; begin a dump.
- dump_busy  output  1  dump in progress.
- dump_done  output  1  single-cycle pulse after the last dump beat is accepted.

Behaviour:
- Reset (reset=0, async): all *_rsp_valid=0, *_rsp_data=0, *_rsp_idx=0, dump_busy=0, dump_done=0, FSM=IDLE, dump counter=0.
- Read value for index i:
  - i==0 always returns 0, regardless of rw_ctrl[0] or reg_q[0].
  - Else if rw_ctrl[i]==0, return wr_data (forwarding).
  - Else return reg_q[i].
- Each channel has a single-entry output register.
  - req_ready = !rsp_valid || rsp_ready.
  - Handshake: req_valid && req_ready. Data and index are captured at that edge, and rsp_valid=1 the next cycle (latency 1).
  - Data is sampled in the handshake cycle; later writes do not alter a held response.
- Response rules:
  - If the response is held (rsp_valid && !rsp_ready), data and index stay stable.
  - If rsp_ready && !new handshake, rsp_valid clears.
  - Back-to-back: response accepted and new request in the same cycle gives full throughput, one per clock.
- Channels A and B are fully independent. Both may address the same register in the same cycle; both get identical data.
- Dump FSM:
  - IDLE:
    - dump_start -> DUMP, counter=0, dump_busy=1.
    - dump_start while busy is ignored.
  - DUMP:
    - a_req_ready=0; external A requests are blocked.
    - FSM injects an internal request with addr=counter whenever the A output register can accept.
    - Counter increments per injected beat.
    - After counter 31 is injected -> DRAIN.
  - DRAIN: wait until the last beat (idx 31) is accepted (a_rsp_valid && a_rsp_ready) -> IDLE. dump_done=1 for exactly that cycle, dump_busy=0 from the next cycle.
- Dump start priority:
  - If dump_start and a_req_valid occur in the same IDLE cycle, the external request wins that cycle (it was ready).
  - The dump begins injecting on the following cycle.
- A pending A response from before the dump drains first, in order.
- Channel B is unaffected by the dump.
- Reset asserted mid-dump: FSM returns to IDLE immediately and all responses are discarded.
- Address width is exactly 5; no out-of-range case exists.

Decomposition:
- Shared package regfile_pkg:
  - NREG, W, ADDR_W constants.
  - typedef reg_idx_t (logic [4:0]).
  - enum dump_state_t {IDLE, DUMP, DRAIN}.
- Sub-module read_chan: one channel, containing forwarding select plus output register and handshake. Instantiate it twice.
- The dump FSM lives in the top level and muxes its request into channel A's read_chan.

Test Plan:
- Preload reg_q[5]=32'hDEAD_BEEF with rw_ctrl all 1. Send A req addr=5 -> next cycle a_rsp_valid=1, a_rsp_data=32'hDEAD_BEEF, a_rsp_idx=5.
- Forwarding and r0:
  - rw_ctrl[7]=0, wr_data=32'h1234_5678, reg_q[7]=0, B req addr=7 in the same cycle -> b_rsp_data=32'h1234_5678.
  - A addr=0 with rw_ctrl[0]=0, wr_data=all-ones -> a_rsp_data=0.
- Backpressure:
  - Hold a_rsp_ready=0 after a response -> a_req_ready=0, data stable for 4 cycles while reg_q changes.
  - Raise a_rsp_ready with a_req_valid=1 addr=3 -> next cycle idx=3.
  - Streaming addrs 1..8 with rsp_ready=1 -> 8 responses in 8 consecutive cycles.
- Dump with reg_q[i]=i*16'h0101:
  - Pulse dump_start -> 32 beats idx 0..31 with data 0, 0x0101, ... (idx 0 data 0).
  - A external requests stalled throughout; dump_done pulses once with the idx-31 acceptance.
  - Toggle a_rsp_ready randomly -> same ordered sequence.
- Reset mid-dump:
  - Assert reset low at beat 10 -> all valid outputs 0 and dump_busy=0 asynchronously.
  - After release, a normal A read addr=2 works.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file read side: sizes, index type, dump FSM states.
package regfile_pkg;
  localparam int NREG   = 32;
  localparam int W      = 32;
  localparam int ADDR_W = $clog2(NREG);

  typedef logic [ADDR_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {IDLE, DUMP, DRAIN} dump_state_t;

  localparam reg_idx_t LAST_IDX = reg_idx_t'(NREG - 1);
endpackage

// File: rtl/read_chan.sv
// One read channel: r0/forwarding select feeding a single-entry response register.
// Latency 1; req_ready drops only while a response is held against rsp_ready=0.
module read_chan
  import regfile_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic [W-1:0]   reg_q [NREG],
  input  logic [NREG-1:0] rw_ctrl,
  input  logic [W-1:0]   wr_data,
  input  logic           req_valid,
  output logic           req_ready,
  input  reg_idx_t       addr,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [W-1:0]   rsp_data,
  output reg_idx_t       rsp_idx
);
  logic [W-1:0] rd_val;
  logic         hs;

  // rw_ctrl low means storage captures wr_data this edge, so return the incoming value.
  always_comb begin
    if (addr == '0)          rd_val = '0;
    else if (!rw_ctrl[addr]) rd_val = wr_data;
    else                     rd_val = reg_q[addr];
  end

  assign req_ready = !rsp_valid || rsp_ready;
  assign hs        = req_valid && req_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_idx   <= '0;
    end else if (hs) begin
      rsp_valid <= 1'b1;
      rsp_data  <= rd_val;
      rsp_idx   <= addr;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/regfile_read_port.sv
// Two independent read channels plus a dump FSM that streams r0..r31 out of channel A.
// Latency 1 per channel; external A requests are blocked while a dump is in progress.
module regfile_read_port
  import regfile_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [W-1:0]    reg_q [NREG],
  input  logic [NREG-1:0] rw_ctrl,
  input  logic [W-1:0]    wr_data,
  input  logic            a_req_valid,
  output logic            a_req_ready,
  input  reg_idx_t        a_addr,
  output logic            a_rsp_valid,
  input  logic            a_rsp_ready,
  output logic [W-1:0]    a_rsp_data,
  output reg_idx_t        a_rsp_idx,
  input  logic            b_req_valid,
  output logic            b_req_ready,
  input  reg_idx_t        b_addr,
  output logic            b_rsp_valid,
  input  logic            b_rsp_ready,
  output logic [W-1:0]    b_rsp_data,
  output reg_idx_t        b_rsp_idx,
  input  logic            dump_start,
  output logic            dump_busy,
  output logic            dump_done
);
  dump_state_t state, state_nxt;
  reg_idx_t    cnt, cnt_nxt;
  logic        chan_a_req_valid;
  logic        chan_a_req_ready;
  reg_idx_t    chan_a_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // In IDLE a same-cycle external A request still goes through; injection starts next cycle.
  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    chan_a_req_valid = a_req_valid;
    chan_a_addr      = a_addr;
    a_req_ready      = chan_a_req_ready;
    dump_done        = 1'b0;
    case (state)
      IDLE: begin
        if (dump_start) begin
          state_nxt = DUMP;
          cnt_nxt   = '0;
        end
      end
      DUMP: begin
        a_req_ready      = 1'b0;
        chan_a_req_valid = 1'b1;
        chan_a_addr      = cnt;
        if (chan_a_req_ready) begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == LAST_IDX) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        a_req_ready      = 1'b0;
        chan_a_req_valid = 1'b0;
        if (a_rsp_valid && a_rsp_ready) begin
          dump_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dump_busy = (state != IDLE);

  read_chan u_chan_a (
    .clk       (clk),
    .reset     (reset),
    .reg_q     (reg_q),
    .rw_ctrl   (rw_ctrl),
    .wr_data   (wr_data),
    .req_valid (chan_a_req_valid),
    .req_ready (chan_a_req_ready),
    .addr      (chan_a_addr),
    .rsp_valid (a_rsp_valid),
    .rsp_ready (a_rsp_ready),
    .rsp_data  (a_rsp_data),
    .rsp_idx   (a_rsp_idx)
  );

  read_chan u_chan_b (
    .clk       (clk),
    .reset     (reset),
    .reg_q     (reg_q),
    .rw_ctrl   (rw_ctrl),
    .wr_data   (wr_data),
    .req_valid (b_req_valid),
    .req_ready (b_req_ready),
    .addr      (b_addr),
    .rsp_valid (b_rsp_valid),
    .rsp_ready (b_rsp_ready),
    .rsp_data  (b_rsp_data),
    .rsp_idx   (b_rsp_idx)
  );
endmodule

// File: tb/tb_regfile_read_port.sv
// Bench for regfile_read_port: directed steps, random traffic against a buffer model, dump sequences.
module tb_regfile_read_port;
  import regfile_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic [W-1:0]    reg_q [NREG];
  logic [NREG-1:0] rw_ctrl;
  logic [W-1:0]    wr_data;
  logic            a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
  reg_idx_t        a_addr, a_rsp_idx;
  logic [W-1:0]    a_rsp_data;
  logic            b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
  reg_idx_t        b_addr, b_rsp_idx;
  logic [W-1:0]    b_rsp_data;
  logic            dump_start, dump_busy, dump_done;

  int tests = 0;
  int fails = 0;

  // Reference: one optional pending response per channel.
  logic         ma_v = 1'b0, mb_v = 1'b0;
  logic [W-1:0] ma_d = '0, mb_d = '0;
  reg_idx_t     ma_i = '0, mb_i = '0;
  bit           a_model_on = 1'b1;
  int           n;
  bit           hit;

  always #5 clk = ~clk;

  regfile_read_port dut (
    .clk(clk), .reset(reset), .reg_q(reg_q), .rw_ctrl(rw_ctrl), .wr_data(wr_data),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_addr(a_addr),
    .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rsp_data(a_rsp_data),
    .a_rsp_idx(a_rsp_idx),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_addr(b_addr),
    .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_data(b_rsp_data),
    .b_rsp_idx(b_rsp_idx),
    .dump_start(dump_start), .dump_busy(dump_busy), .dump_done(dump_done)
  );

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_read(input reg_idx_t i);
    if (i == 0) return '0;
    if (!rw_ctrl[i]) return wr_data;
    return reg_q[i];
  endfunction

  // Check outputs against the model at the negedge, then advance the model across the posedge.
  task automatic cyc();
    logic a_hs, b_hs;
    logic [W-1:0] a_nd, b_nd;
    reg_idx_t a_na, b_na;
    @(negedge clk);
    if (a_model_on) begin
      chk(a_rsp_valid, ma_v, "a_rsp_valid");
      chk(a_req_ready, !ma_v || a_rsp_ready, "a_req_ready");
      if (ma_v) begin
        chk(a_rsp_data, ma_d, "a_rsp_data");
        chk(a_rsp_idx, ma_i, "a_rsp_idx");
      end
    end
    chk(b_rsp_valid, mb_v, "b_rsp_valid");
    chk(b_req_ready, !mb_v || b_rsp_ready, "b_req_ready");
    if (mb_v) begin
      chk(b_rsp_data, mb_d, "b_rsp_data");
      chk(b_rsp_idx, mb_i, "b_rsp_idx");
    end
    a_hs = a_req_valid && (!ma_v || a_rsp_ready);
    b_hs = b_req_valid && (!mb_v || b_rsp_ready);
    a_nd = ref_read(a_addr);
    b_nd = ref_read(b_addr);
    a_na = a_addr;
    b_na = b_addr;
    @(posedge clk);
    if (a_hs) begin ma_v = 1'b1; ma_d = a_nd; ma_i = a_na; end
    else if (a_rsp_ready) ma_v = 1'b0;
    if (b_hs) begin mb_v = 1'b1; mb_d = b_nd; mb_i = b_na; end
    else if (b_rsp_ready) mb_v = 1'b0;
    #1;
  endtask

  task automatic load_dump_pattern();
    for (int i = 0; i < NREG; i++) reg_q[i] = i * 32'h0101;
    rw_ctrl = '1;
  endtask

  // Expect an optional external beat (idx 4) followed by beats 0..31; done with the idx-31 acceptance.
  task automatic run_dump(input bit rnd, input bit pre);
    int exp_q[$];
    int got = 0;
    int cn = 0;
    bit acc;
    if (pre) exp_q.push_back(4);
    for (int i = 0; i < NREG; i++) exp_q.push_back(i);
    a_model_on = 1'b0;
    dump_start  = 1'b1;
    a_req_valid = pre;
    a_addr      = 5'd4;
    a_rsp_ready = !pre;
    @(negedge clk);
    chk(dump_busy, 0, "dump_busy_before_start");
    chk(a_req_ready, 1, "a_req_ready_start_cycle");
    @(posedge clk); #1;
    dump_start = 1'b0;
    while (got < exp_q.size() && cn < 400) begin
      a_req_valid = 1'($urandom_range(1));
      a_addr      = 5'd17;
      a_rsp_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
      @(negedge clk);
      cn++;
      chk(dump_busy, 1, "dump_busy");
      chk(a_req_ready, 0, "a_req_ready_dump");
      acc = a_rsp_valid && a_rsp_ready;
      chk(dump_done, acc && (got == exp_q.size() - 1), "dump_done");
      if (acc) begin
        chk(a_rsp_idx, exp_q[got], "dump_idx");
        chk(a_rsp_data, exp_q[got] * 32'h0101, "dump_data");
        got++;
      end
      @(posedge clk); #1;
    end
    chk(got, exp_q.size(), "dump_beat_count");
    a_req_valid = 1'b0;
    a_rsp_ready = 1'b1;
    @(negedge clk);
    chk(dump_busy, 0, "dump_busy_after_done");
    chk(dump_done, 0, "dump_done_single");
    chk(a_rsp_valid, 0, "a_rsp_valid_after_dump");
    @(posedge clk); #1;
    ma_v = 1'b0;
    a_model_on = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    load_dump_pattern();
    wr_data = '0;
    a_req_valid = 1'b0; a_addr = '0; a_rsp_ready = 1'b1;
    b_req_valid = 1'b0; b_addr = '0; b_rsp_ready = 1'b1;
    dump_start = 1'b0;
    #12;
    chk(a_rsp_valid, 0, "rst_a_valid");
    chk(b_rsp_valid, 0, "rst_b_valid");
    chk(a_rsp_data, 0, "rst_a_data");
    chk(a_rsp_idx, 0, "rst_a_idx");
    chk(dump_busy, 0, "rst_busy");
    chk(dump_done, 0, "rst_done");
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Plain read
    reg_q[5] = 32'hDEAD_BEEF;
    a_req_valid = 1'b1; a_addr = 5'd5;
    cyc();
    a_req_valid = 1'b0;
    chk(a_rsp_valid, 1, "rd5_valid");
    chk(a_rsp_data, 32'hDEAD_BEEF, "rd5_data");
    chk(a_rsp_idx, 5, "rd5_idx");

    // Forwarding on B
    rw_ctrl[7] = 1'b0; wr_data = 32'h1234_5678; reg_q[7] = '0;
    b_req_valid = 1'b1; b_addr = 5'd7;
    cyc();
    b_req_valid = 1'b0; rw_ctrl = '1;
    chk(b_rsp_data, 32'h1234_5678, "fwd_b_data");

    // r0 ignores forwarding
    rw_ctrl[0] = 1'b0; wr_data = '1;
    a_req_valid = 1'b1; a_addr = 5'd0;
    cyc();
    a_req_valid = 1'b0; rw_ctrl = '1;
    chk(a_rsp_valid, 1, "r0_valid");
    chk(a_rsp_data, 0, "r0_data");

    // Backpressure: held response stays stable while storage changes
    reg_q[9] = 32'hCAFE_0009;
    a_req_valid = 1'b1; a_addr = 5'd9;
    cyc();
    a_req_valid = 1'b0; a_rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      reg_q[9] = $urandom;
      cyc();
      chk(a_req_ready, 0, "bp_req_ready");
      chk(a_rsp_data, 32'hCAFE_0009, "bp_data_stable");
    end
    a_rsp_ready = 1'b1; a_req_valid = 1'b1; a_addr = 5'd3;
    cyc();
    chk(a_rsp_idx, 3, "bp_release_idx");

    // Streaming, one response per clock
    for (int k = 1; k <= 8; k++) begin
      a_addr = reg_idx_t'(k);
      cyc();
      chk(a_rsp_valid, 1, "stream_valid");
      chk(a_rsp_idx, k, "stream_idx");
    end
    a_req_valid = 1'b0;
    cyc();

    // Random traffic on both channels
    for (int k = 0; k < 300; k++) begin
      a_req_valid = 1'($urandom_range(1));
      a_addr      = reg_idx_t'($urandom_range(NREG - 1));
      a_rsp_ready = ($urandom_range(3) != 0);
      b_req_valid = 1'($urandom_range(1));
      b_addr      = ($urandom_range(3) == 0) ? a_addr : reg_idx_t'($urandom_range(NREG - 1));
      b_rsp_ready = ($urandom_range(3) != 0);
      wr_data     = $urandom;
      rw_ctrl     = $urandom_range(1) ? ~(32'h1 << $urandom_range(NREG - 1)) : '1;
      if ($urandom_range(3) == 0) rw_ctrl[0] = 1'b0;
      reg_q[$urandom_range(NREG - 1)] = $urandom;
      cyc();
    end
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
    cyc();
    cyc();

    // Dumps
    load_dump_pattern();
    run_dump(1'b0, 1'b0);
    run_dump(1'b1, 1'b1);

    // Reset in the middle of a dump, with a B response pending
    dump_start = 1'b1; a_model_on = 1'b0;
    b_req_valid = 1'b1; b_addr = 5'd6; b_rsp_ready = 1'b0;
    @(posedge clk); #1;
    dump_start = 1'b0; b_req_valid = 1'b0;
    n = 0; hit = 1'b0;
    while (!hit && n < 100) begin
      @(negedge clk);
      n++;
      if (a_rsp_valid && a_rsp_ready && a_rsp_idx == 5'd10) hit = 1'b1;
    end
    chk(hit, 1, "reach_beat10");
    #2 reset = 1'b0;
    #1;
    chk(a_rsp_valid, 0, "mid_rst_a_valid");
    chk(b_rsp_valid, 0, "mid_rst_b_valid");
    chk(a_rsp_data, 0, "mid_rst_a_data");
    chk(dump_busy, 0, "mid_rst_busy");
    chk(dump_done, 0, "mid_rst_done");
    @(negedge clk); #2 reset = 1'b1;
    @(posedge clk); #1;
    ma_v = 1'b0; mb_v = 1'b0;
    b_rsp_ready = 1'b1; a_model_on = 1'b1;
    a_req_valid = 1'b1; a_addr = 5'd2;
    cyc();
    a_req_valid = 1'b0;
    chk(a_rsp_valid, 1, "post_rst_valid");
    chk(a_rsp_data, 32'h0202, "post_rst_data");
    chk(a_rsp_idx, 2, "post_rst_idx");
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
